// File: rtl/fir_input_fifo_pkg.sv
// Shared defaults for the FIR input path: sample width, FIFO depth, pointer width helper.
package fir_input_fifo_pkg;
  localparam int FIR_DATA_WIDTH = 24;
  localparam int FIR_FIFO_DEPTH = 16;

  // Pointer width for a power-of-two depth; the FIR core reuses this for its tap buffer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fir_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read (distributed RAM).
module fir_fifo_mem
  import fir_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DEPTH      = FIR_FIFO_DEPTH,
  localparam int AW        = ptr_w(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         iv_waddr,
  input  logic [DATA_WIDTH-1:0] iv_wdata,
  input  logic [AW-1:0]         iv_raddr,
  output logic [DATA_WIDTH-1:0] ov_rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[iv_waddr] <= iv_wdata;
  end

  assign ov_rdata = mem[iv_raddr];
endmodule

// File: rtl/fir_input_fifo.sv
// FWFT elastic sample buffer ahead of the FIR core; head held until i_consumed.
// Define FIR_INPUT_FIFO_STATS_EN to add drop-count and high-water outputs.
module fir_input_fifo
  import fir_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = FIR_DATA_WIDTH,
  parameter int FIFO_DEPTH   = FIR_FIFO_DEPTH,
  parameter int AFULL_THRESH = 12,
  localparam int AW          = ptr_w(FIFO_DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic                  i_din_valid,
  output logic                  o_din_ready,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic                  o_dout_valid,
  input  logic                  i_consumed,
  output logic [CW-1:0]         ov_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
`ifdef FIR_INPUT_FIFO_STATS_EN
  output logic [15:0]           ov_drop_count,
  output logic [CW-1:0]         ov_high_water,
`endif
  output logic                  o_overflow
);
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  full_q, empty_q, afull_q, ovf_q;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Push is gated by registered full, so a same-cycle pop never frees a slot early.
  assign push      = i_din_valid && !full_q;
  assign pop       = i_consumed && !empty_q;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      full_q  <= (count_nxt == CW'(FIFO_DEPTH));
      empty_q <= (count_nxt == '0);
      afull_q <= (count_nxt >= CW'(AFULL_THRESH));
      if (i_din_valid && full_q) ovf_q <= 1'b1;
    end
  end

  fir_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_mem (
    .i_clk    (i_clk),
    .i_we     (push),
    .iv_waddr (wr_ptr),
    .iv_wdata (iv_din),
    .iv_raddr (rd_ptr),
    .ov_rdata (rd_data)
  );

`ifdef FIR_INPUT_FIFO_STATS_EN
  logic [15:0]   drop_q;
  logic [CW-1:0] hw_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_q <= '0;
      hw_q   <= '0;
    end else begin
      if (i_din_valid && full_q && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (count_nxt > hw_q) hw_q <= count_nxt;
    end
  end

  assign ov_drop_count = drop_q;
  assign ov_high_water = hw_q;
`endif

  assign ov_dout      = empty_q ? '0 : rd_data;
  assign o_dout_valid = !empty_q;
  assign o_din_ready  = !full_q;
  assign ov_count     = count;
  assign o_full       = full_q;
  assign o_empty      = empty_q;
  assign o_afull      = afull_q;
  assign o_overflow   = ovf_q;
endmodule
